// File: rtl/round_controller_if.sv
// Signal bundle between the round controller and the start button / column / score logic.
// The controller drives the master side; the surrounding game logic uses the slave side.
interface round_controller_if;
    logic       start;
    logic [9:0] score;
    logic       scroll_tick;
    logic       score_en;
    logic       clear_score;
    logic [1:0] state;
    logic [1:0] cd_digit;
    logic [1:0] level;
    logic [9:0] time_left;
    logic       game_over;

    modport master (
        input  start, score,
        output scroll_tick, score_en, clear_score, state, cd_digit, level, time_left, game_over
    );

    modport slave (
        output start, score,
        input  scroll_tick, score_en, clear_score, state, cd_digit, level, time_left, game_over
    );
endinterface

// File: rtl/round_controller.sv
// Rhythm-game round sequencer: idle, 3-2-1 countdown, timed play, game over.
// Produces the level-dependent light-scroll tick and gates/clears the score datapath.
module round_controller #(
    parameter int unsigned TICK_DIV    = 50000000,
    parameter int unsigned ROUND_TICKS = 60,
    parameter int unsigned LEVEL_STEP  = 100,
    parameter int unsigned MAX_LEVEL   = 3
) (
    input  logic               clk,
    input  logic               reset,
    round_controller_if.master bus
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        DONE      = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic             start_q;
    logic [CNT_W-1:0] base_cnt_q, base_cnt_d;
    logic [1:0]       cd_digit_q, cd_digit_d;
    logic [9:0]       time_left_q, time_left_d;
    logic [1:0]       level_q, level_d;
    logic [1:0]       sub_cnt_q, sub_cnt_d;
    logic             scroll_q, scroll_d;
    logic             clear_q, clear_d;
    logic             score_en_q, score_en_d;
    logic             game_over_q, game_over_d;

    logic             start_rise;
    logic             base_tick;
    logic [31:0]      score_quot;
    logic [1:0]       level_cap;

    assign start_rise = bus.start & ~start_q;
    assign base_tick  = ((state_q == COUNTDOWN) || (state_q == PLAY))
                        && (base_cnt_q == CNT_W'(TICK_DIV - 1));

    // Speed level implied by the current score, saturated at MAX_LEVEL
    assign score_quot = 32'(bus.score) / 32'(LEVEL_STEP);
    assign level_cap  = (score_quot >= 32'(MAX_LEVEL)) ? 2'(MAX_LEVEL) : score_quot[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            base_cnt_q  <= '0;
            cd_digit_q  <= 2'd0;
            time_left_q <= 10'd0;
            level_q     <= 2'd0;
            sub_cnt_q   <= 2'd0;
            scroll_q    <= 1'b0;
            clear_q     <= 1'b0;
            score_en_q  <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= bus.start;
            base_cnt_q  <= base_cnt_d;
            cd_digit_q  <= cd_digit_d;
            time_left_q <= time_left_d;
            level_q     <= level_d;
            sub_cnt_q   <= sub_cnt_d;
            scroll_q    <= scroll_d;
            clear_q     <= clear_d;
            score_en_q  <= score_en_d;
            game_over_q <= game_over_d;
        end
    end

    // Next-state and registered-output logic; base_cnt_d defaults to 0 so every state entry restarts it
    always_comb begin
        state_d     = state_q;
        base_cnt_d  = '0;
        cd_digit_d  = cd_digit_q;
        time_left_d = time_left_q;
        level_d     = level_q;
        sub_cnt_d   = sub_cnt_q;
        scroll_d    = 1'b0;
        clear_d     = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    state_d     = COUNTDOWN;
                    clear_d     = 1'b1;
                    cd_digit_d  = 2'd3;
                    time_left_d = 10'(ROUND_TICKS);
                    level_d     = 2'd0;
                    sub_cnt_d   = 2'd0;
                end
            end
            COUNTDOWN: begin
                base_cnt_d = base_tick ? '0 : base_cnt_q + CNT_W'(1);
                if (base_tick) begin
                    if (cd_digit_q == 2'd1) begin
                        state_d    = PLAY;
                        cd_digit_d = 2'd0;
                    end else begin
                        cd_digit_d = cd_digit_q - 2'd1;
                    end
                end
            end
            PLAY: begin
                base_cnt_d = base_tick ? '0 : base_cnt_q + CNT_W'(1);
                level_d    = (level_cap > level_q) ? level_cap : level_q;
                if (base_tick) begin
                    time_left_d = time_left_q - 10'd1;
                    if (time_left_q == 10'd1) begin
                        state_d = DONE;
                    end
                    // >= lets a mid-period level rise shorten the current period
                    if (sub_cnt_q >= (2'd3 - level_q)) begin
                        sub_cnt_d = 2'd0;
                        scroll_d  = 1'b1;
                    end else begin
                        sub_cnt_d = sub_cnt_q + 2'd1;
                    end
                end
            end
        endcase

        score_en_d  = (state_d == PLAY);
        game_over_d = (state_d == DONE);
    end

    assign bus.scroll_tick = scroll_q;
    assign bus.score_en    = score_en_q;
    assign bus.clear_score = clear_q;
    assign bus.state       = state_q;
    assign bus.cd_digit    = cd_digit_q;
    assign bus.level       = level_q;
    assign bus.time_left   = time_left_q;
    assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with TICK_DIV=4, ROUND_TICKS=8, LEVEL_STEP=10, MAX_LEVEL=3.
module tb_round_controller;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    round_controller_if bus ();

    round_controller #(
        .TICK_DIV   (4),
        .ROUND_TICKS(8),
        .LEVEL_STEP (10),
        .MAX_LEVEL  (3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [19:0] outs;
    assign outs = {bus.scroll_tick, bus.score_en, bus.clear_score, bus.state,
                   bus.cd_digit, bus.level, bus.time_left, bus.game_over};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Start pulse from IDLE/DONE; returns at the first PLAY cycle
    task automatic do_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk("cd_state", 32'(bus.state), 32'd1);
            chk("cd_digit", 32'(bus.cd_digit), 32'(3 - k / 4));
            chk("cd_clear", 32'(bus.clear_score), (k == 0) ? 32'd1 : 32'd0);
            chk("cd_score_en", 32'(bus.score_en), 32'd0);
            if (k == 0) begin
                chk("start_time_left", 32'(bus.time_left), 32'd8);
                chk("start_level", 32'(bus.level), 32'd0);
            end
            @(negedge clk);
        end
        chk("play_state", 32'(bus.state), 32'd2);
        chk("play_cd", 32'(bus.cd_digit), 32'd0);
        chk("play_time_left", 32'(bus.time_left), 32'd8);
        chk("play_score_en", 32'(bus.score_en), 32'd1);
    endtask

    initial begin
        int clr_cnt;
        int exp_tl;
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.score = 10'd0;

        // 1: reset and idle
        @(negedge clk);
        chk("rst_outs", 32'(outs), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_outs", 32'(outs), 32'd0);
        end

        // 2: countdown sequence
        do_start();

        // 3: play at level 0, two scroll ticks, end of round
        for (int p = 0; p < 34; p++) begin
            exp_tl = (p < 32) ? 8 - p / 4 : 0;
            chk("l0_time_left", 32'(bus.time_left), 32'(exp_tl));
            chk("l0_scroll", 32'(bus.scroll_tick), (p == 16 || p == 32) ? 32'd1 : 32'd0);
            chk("l0_state", 32'(bus.state), (p < 32) ? 32'd2 : 32'd3);
            chk("l0_game_over", 32'(bus.game_over), (p >= 32) ? 32'd1 : 32'd0);
            chk("l0_score_en", 32'(bus.score_en), (p < 32) ? 32'd1 : 32'd0);
            @(negedge clk);
        end

        // 4: level 2 from score 25, held after a drop, level 3 at score 999
        bus.score = 10'd25;
        do_start();
        for (int p = 0; p < 34; p++) begin
            chk("lv_level", 32'(bus.level), (p == 0) ? 32'd0 : (p < 18) ? 32'd2 : 32'd3);
            chk("lv_scroll", 32'(bus.scroll_tick),
                (p == 8 || p == 16 || p == 20 || p == 24 || p == 28 || p == 32) ? 32'd1 : 32'd0);
            if (p == 10) bus.score = 10'd5;
            if (p == 17) bus.score = 10'd999;
            @(negedge clk);
        end
        chk("lv_done_level", 32'(bus.level), 32'd3);
        chk("lv_done_time_left", 32'(bus.time_left), 32'd0);

        // 5: start held high from IDLE gives one round start
        reset = 1'b0;
        @(negedge clk);
        reset     = 1'b1;
        bus.score = 10'd999;
        bus.start = 1'b1;
        clr_cnt   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.clear_score) clr_cnt++;
        end
        chk("hold_clear_count", 32'(clr_cnt), 32'd1);
        chk("hold_state", 32'(bus.state), 32'd2);
        bus.start = 1'b0;
        for (int i = 0; i < 20 && !bus.game_over; i++) @(negedge clk);
        chk("hold_game_over", 32'(bus.game_over), 32'd1);
        chk("hold_done_level", 32'(bus.level), 32'd3);
        @(negedge clk);
        chk("done_hold_state", 32'(bus.state), 32'd3);
        do_start();

        // 6: asynchronous reset mid-play
        bus.score = 10'd0;
        repeat (13) @(negedge clk);
        chk("mid_time_left", 32'(bus.time_left), 32'd5);
        #2 reset = 1'b0;
        #1 chk("async_rst_outs", 32'(outs), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_outs", 32'(outs), 32'd0);
        end
        do_start();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
